seven_seg_mux: RTL
==================

# seven_seg_mux

Time-multiplexed controller that shares one `seven_seg_disp` hex decoder between two common-anode digits on the board. It scans digit 0, then digit 1, at a parameterised refresh rate. It inserts blanking gaps between digits so that no digit ghosts into its neighbour. It drives the decoder's 4-bit input and the two active-low anode selects, and passes the decoder's 7-bit segment output straight to the pins.

## Interface
- `REFRESH_DIV`, default 2500: cycles each digit is lit per scan slot; must be ≥2.
- `BLANK_CYCLES`, default 50: cycles with both anodes off between slots; must be ≥1.
- `clk` input 1: system clock.
- `reset` input 1: synchronous, active-high reset.
- `s0` input 4: hex value for digit 0.
- `s1` input 4: hex value for digit 1.
- `en0` input 1: digit 0 enable; when low, digit 0's anode stays off during its slot.
- `en1` input 1: digit 1 enable; same rule as `en0`, for digit 1.
- `anode_n` output 2: active-low anode selects; bit 0 is digit 0, bit 1 is digit 1.
- `seg` output 7: segment pattern from the internal `seven_seg_disp`.
- `s_sel` output 4: value currently presented to the decoder; exposed for debug.
- `frame_tick` output 1: one-cycle pulse at the start of each scan frame.

## Operation
- FSM states, in cyclic order: SHOW0 → BLANK0 → SHOW1 → BLANK1 → SHOW0.
- Slot counter `cnt` is shared by all states.
  - Width: `$clog2(max(REFRESH_DIV, BLANK_CYCLES))`.
  - Cleared on every state transition; increments by 1 otherwise.
- Exit conditions:
  - SHOW states exit when `cnt == REFRESH_DIV-1`.
  - BLANK states exit when `cnt == BLANK_CYCLES-1`.
- `s_sel`, `anode_n` and `frame_tick` are registered and update on the same edge the FSM changes state.
  - Entering SHOW0: `s_sel <= s0`, `anode_n <= en0 ? 2'b10 : 2'b11`, `frame_tick <= 1`.
  - Entering SHOW1: `s_sel <= s1`, `anode_n <= en1 ? 2'b01 : 2'b11`.
  - Entering BLANK0 or BLANK1: `anode_n <= 2'b11`; `s_sel` holds its value.
  - `frame_tick` is 0 in every other cycle.
- Digit values are captured only on SHOW entry.
  - Changes to `s0`/`s1`/`en0`/`en1` mid-slot take effect at that digit's next slot.
  - No tearing within a slot.
- A disabled digit still consumes its full slot. Frame period is constant at `2*(REFRESH_DIV+BLANK_CYCLES)`, so brightness does not depend on the enables.
- `seg` is combinational from `s_sel` through `seven_seg_disp`. `seg` is valid whenever an anode is low.
- The two anodes are never low in the same cycle, including across reset.

## Timing
- Reset values: state = BLANK1, `cnt` = 0, `anode_n` = 2'b11, `s_sel` = 4'h0, `frame_tick` = 0. `seg` = decode of 4'h0.
- After reset deasserts, the FSM completes BLANK1 (`BLANK_CYCLES` edges). On the last of those edges it enters SHOW0; the first lit digit-0 cycle follows that edge.
- Latency from `s0` to lit digit: up to one frame period plus 1 cycle.
- Reset asserted mid-operation, in any state: on the next edge, both anodes are off and the FSM is in BLANK1.
- Simultaneous reset and state-exit condition: reset wins.

## Structure
- Shared package `seven_seg_pkg`:
  - `typedef enum logic [1:0] {SHOW0, BLANK0, SHOW1, BLANK1} scan_state_t`.
  - `localparam logic [1:0] ANODES_OFF = 2'b11`.
- One sub-module: the existing `seven_seg_disp` (input `s`, output `seg`), instantiated once and driven by `s_sel`.
- No other hierarchy: FSM, counter and output registers live in `seven_seg_mux`.

## Test plan
Parameters for all scenarios: `REFRESH_DIV=4`, `BLANK_CYCLES=2`; edges counted from reset release.
- Reset → `anode_n=2'b11`, `s_sel=4'h0`, `frame_tick=0`.
  - With `s0=4'hA`, `en0=1`: `anode_n=2'b10` and `s_sel=4'hA` after the 2nd edge.
  - `frame_tick` is high for exactly that one cycle.
- Full frame with `s0=4'h3`, `s1=4'hC`, both enabled:
  - `anode_n` sequence: 10×4, 11×2, 01×4, 11×2, repeating.
  - Period is 12 cycles; `s_sel` alternates 3/C.
  - `seg` matches `seven_seg_disp` decode of `s_sel` at every lit cycle.
- Change `s1` from 4'h5 to 4'h9 in the middle of the SHOW1 slot:
  - `s_sel` stays 5 until that slot ends.
  - The next SHOW1 slot shows 9.
- `en1=0`: slot 1 has `anode_n=2'b11` for all 4 cycles, and the frame period is still 12.
- Assert reset during SHOW0: next edge gives `anode_n=2'b11`. After release, the 2-cycle BLANK1 → SHOW0 sequence repeats as in scenario 1.
- All scenarios: assert on every cycle that `anode_n != 2'b00`.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// -----------------------------------------------------------------------------
// seven_seg_pkg
// Shared types and constants for the two-digit seven-segment scan controller.
//   scan_state_t : scan slot sequence SHOW0 -> BLANK0 -> SHOW1 -> BLANK1
//   ANODES_OFF   : active-low anode pattern with both digits dark
// -----------------------------------------------------------------------------
package seven_seg_pkg;

  typedef enum logic [1:0] {
    SHOW0,
    BLANK0,
    SHOW1,
    BLANK1
  } scan_state_t;

  localparam logic [1:0] ANODES_OFF = 2'b11;

endpackage : seven_seg_pkg

// File: rtl/seven_seg_disp.sv
// -----------------------------------------------------------------------------
// seven_seg_disp
// Hex to seven-segment decoder for common-anode displays.
// Segments are active-low and ordered {g,f,e,d,c,b,a} (seg[0] = a).
//   s   : 4-bit hex value to display
//   seg : segment pattern, 0 = segment lit
// -----------------------------------------------------------------------------
module seven_seg_disp (
  input  logic [3:0] s,
  output logic [6:0] seg
);

  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path
    // (here through the default arm) so no latch is inferred.
    seg = 7'b111_1111;
    case (s)
      4'h0: seg = 7'b100_0000;
      4'h1: seg = 7'b111_1001;
      4'h2: seg = 7'b010_0100;
      4'h3: seg = 7'b011_0000;
      4'h4: seg = 7'b001_1001;
      4'h5: seg = 7'b001_0010;
      4'h6: seg = 7'b000_0010;
      4'h7: seg = 7'b111_1000;
      4'h8: seg = 7'b000_0000;
      4'h9: seg = 7'b001_0000;
      4'hA: seg = 7'b000_1000;
      4'hB: seg = 7'b000_0011;
      4'hC: seg = 7'b100_0110;
      4'hD: seg = 7'b010_0001;
      4'hE: seg = 7'b000_0110;
      4'hF: seg = 7'b000_1110;
      default: seg = 7'b111_1111;
    endcase
  end

endmodule : seven_seg_disp

// File: rtl/seven_seg_mux.sv
// -----------------------------------------------------------------------------
// seven_seg_mux
// Time-multiplexed scan of two common-anode digits through one shared decoder.
// Each digit gets a REFRESH_DIV-cycle slot followed by BLANK_CYCLES cycles with
// both anodes off, so one digit never ghosts into the next.
//   REFRESH_DIV  : cycles a digit is lit per slot (>= 2)
//   BLANK_CYCLES : dark cycles between slots (>= 1)
//   clk          : system clock
//   reset        : synchronous, active-high reset
//   s0, s1       : hex values for digit 0 / digit 1
//   en0, en1     : digit enables; a disabled digit stays dark but keeps its slot
//   anode_n      : active-low anode selects, bit 0 = digit 0
//   seg          : active-low segment pattern for the currently selected value
//   s_sel        : value presented to the decoder (debug)
//   frame_tick   : one-cycle pulse on the first cycle of each frame (SHOW0 entry)
// -----------------------------------------------------------------------------
module seven_seg_mux
  import seven_seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 2500,
  parameter int BLANK_CYCLES = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] s0,
  input  logic [3:0] s1,
  input  logic       en0,
  input  logic       en1,
  output logic [1:0] anode_n,
  output logic [6:0] seg,
  output logic [3:0] s_sel,
  output logic       frame_tick
);

  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX);

  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  scan_state_t   state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [1:0]    anode_d;
  logic [3:0]    s_sel_d;
  logic          tick_d;
  logic          slot_done;

  // Next-state and next-output logic. Outputs are computed for the state being
  // entered so the registered outputs change on the same edge as the FSM, and
  // digit values/enables are captured only at SHOW entry (no mid-slot tearing).
  always_comb begin
    state_d   = state;
    cnt_d     = cnt + CW'(1);
    anode_d   = anode_n;
    s_sel_d   = s_sel;
    tick_d    = 1'b0;
    slot_done = 1'b0;

    case (state)
      SHOW0, SHOW1:   slot_done = (cnt == SHOW_LAST);
      BLANK0, BLANK1: slot_done = (cnt == BLANK_LAST);
      default:        slot_done = 1'b1;
    endcase

    if (slot_done) begin
      cnt_d = '0;
      case (state)
        SHOW0: begin
          state_d = BLANK0;
          anode_d = ANODES_OFF;
        end
        BLANK0: begin
          state_d = SHOW1;
          s_sel_d = s1;
          anode_d = en1 ? 2'b01 : ANODES_OFF;
        end
        SHOW1: begin
          state_d = BLANK1;
          anode_d = ANODES_OFF;
        end
        BLANK1: begin
          state_d = SHOW0;
          s_sel_d = s0;
          anode_d = en0 ? 2'b10 : ANODES_OFF;
          tick_d  = 1'b1;
        end
        default: begin
          state_d = BLANK1;
          anode_d = ANODES_OFF;
        end
      endcase
    end
  end

  // Reset parks the scan in BLANK1 with both anodes off, so the first lit
  // digit appears BLANK_CYCLES edges after release and never overlaps another.
  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples its inputs from before the edge, independent of statement order.
    if (reset) begin
      state      <= BLANK1;
      cnt        <= '0;
      anode_n    <= ANODES_OFF;
      s_sel      <= 4'h0;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      anode_n    <= anode_d;
      s_sel      <= s_sel_d;
      frame_tick <= tick_d;
    end
  end

  seven_seg_disp u_disp (
    .s   (s_sel),
    .seg (seg)
  );

endmodule : seven_seg_mux
